// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
// The master modport belongs to the requester side; the slave modport belongs to the arbiter.
interface rr_decoder_arbiter_if #(
  parameter int IDX_W = 3
);
  localparam int N = 2 ** IDX_W;

  logic             enable;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             busy;
  logic             timeout;

  modport master (
    output enable, req, done,
    input  gnt, gnt_idx, gnt_valid, busy, timeout
  );

  modport slave (
    input  enable, req, done,
    output gnt, gnt_idx, gnt_valid, busy, timeout
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// 8-way round-robin arbiter with a registered winner index decoded to a one-hot grant.
// Define RR_ARB_TIMEOUT_EN to add a hold counter that force-releases grants after MAX_HOLD cycles.
module rr_decoder_arbiter #(
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input logic                 clk,
  input logic                 rst,
  rr_decoder_arbiter_if.slave bus
);
  localparam int N = 2 ** IDX_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
  logic [N-1:0]     gnt_reg, gnt_next;
  logic             gnt_valid_reg, gnt_valid_next;
  logic             timeout_reg, timeout_next;

  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_onehot;
  logic             win_found;
  logic             normal_release;
  logic             force_release;

  // Scan upward from ptr with natural IDX_W-bit wrap; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_reg;
    for (int k = 0; k < N; k++) begin
      if (!win_found && bus.req[ptr_reg + IDX_W'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_reg + IDX_W'(k);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
      assign win_onehot[gi] = (win_idx == IDX_W'(gi));
    end
  endgenerate

  assign normal_release = bus.done | ~bus.req[gnt_idx_reg] | ~bus.enable;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_reg, hold_cnt_next;

  assign force_release = (hold_cnt_reg == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (state_reg != ST_GRANT) begin
      hold_cnt_next = 8'd0;
    end else if (!normal_release && !force_release) begin
      hold_cnt_next = hold_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_reg <= 8'd0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end
`else
  logic [7:0] unused_max_hold;

  assign unused_max_hold = 8'(MAX_HOLD);
  assign force_release   = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_idx_next   = gnt_idx_reg;
    gnt_next       = gnt_reg;
    gnt_valid_next = gnt_valid_reg;
    timeout_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.enable && win_found) begin
          gnt_idx_next   = win_idx;
          gnt_next       = win_onehot;
          gnt_valid_next = 1'b1;
          state_next     = ST_GRANT;
        end else begin
          gnt_next       = '0;
          gnt_valid_next = 1'b0;
        end
      end
      ST_GRANT: begin
        // A normal release on the same edge as the hold limit suppresses the timeout pulse.
        if (normal_release || force_release) begin
          gnt_next       = '0;
          gnt_valid_next = 1'b0;
          ptr_next       = gnt_idx_reg + IDX_W'(1);
          timeout_next   = ~normal_release;
          state_next     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        state_next     = ST_IDLE;
      end
      default: begin
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        state_next     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_reg       <= '0;
      gnt_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_reg       <= gnt_next;
      gnt_valid_reg <= gnt_valid_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_idx   = gnt_idx_reg;
  assign bus.gnt_valid = gnt_valid_reg;
  assign bus.busy      = gnt_valid_reg;
  assign bus.timeout   = timeout_reg;
endmodule
